// File: rtl/pgm_pkg.sv
// Shared definitions for the multi-slot packet generator: beat header codes,
// header field position and the generator FSM state encoding.
package pgm_pkg;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_BODY = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  localparam int HDR_HI = 133;
  localparam int HDR_LO = 132;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_GAP
  } gen_state_t;

endpackage

// File: rtl/pgm_tpl_ram.sv
// Template store: SLOTS*SLOT_DEPTH x DATA_W dual-port RAM with 1-cycle read,
// per-slot write index, recorded length and valid bit; flags overlong templates.
module pgm_tpl_ram
  import pgm_pkg::*;
#(
  parameter  int DATA_W     = 134,
  parameter  int SLOTS      = 4,
  parameter  int SLOT_DEPTH = 32,
  localparam int SW         = $clog2(SLOTS),
  localparam int AW         = $clog2(SLOT_DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_en,
  input  logic [SW-1:0]          i_wr_slot,
  input  logic [DATA_W-1:0]      i_wr_data,
  input  logic [SW+AW-1:0]       i_rd_addr,
  output logic [DATA_W-1:0]      o_rd_data,
  output logic [SLOTS-1:0]       o_slot_valid,
  output logic [SLOTS-1:0][AW:0] o_slot_len,
  output logic                   o_ovf
);

  logic [DATA_W-1:0]      r_mem [SLOTS*SLOT_DEPTH];
  logic [DATA_W-1:0]      r_rd_data;
  logic [SLOTS-1:0][AW:0] r_widx;
  logic [SLOTS-1:0][AW:0] r_len;
  logic [SLOTS-1:0]       r_valid;
  logic                   r_ovf;

  logic [1:0]  w_hdr;
  logic [AW:0] w_idx;
  logic        w_fit;

  assign w_hdr = i_wr_data[HDR_HI:HDR_LO];
  assign w_idx = (w_hdr == HDR_HEAD) ? '0 : r_widx[i_wr_slot];
  // The write index saturates at SLOT_DEPTH, so its MSB marks an overlong template
  assign w_fit = !w_idx[AW];

  always_ff @(posedge clk) begin
    if (i_wr_en && w_fit)
      r_mem[{i_wr_slot, w_idx[AW-1:0]}] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_widx  <= '0;
      r_len   <= '0;
      r_valid <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (i_wr_en) begin
        if (w_hdr == HDR_HEAD) r_valid[i_wr_slot] <= 1'b0;
        if (w_fit) begin
          r_widx[i_wr_slot] <= w_idx + LW'(1);
          if (w_hdr == HDR_TAIL) begin
            r_valid[i_wr_slot] <= 1'b1;
            r_len[i_wr_slot]   <= w_idx + LW'(1);
          end
        end else begin
          r_valid[i_wr_slot] <= 1'b0;
          r_ovf              <= 1'b1;
        end
      end
    end
  end

  assign o_rd_data    = r_rd_data;
  assign o_slot_valid = r_valid;
  assign o_slot_len   = r_len;
  assign o_ovf        = r_ovf;

endmodule

// File: rtl/pgm_multi_gen.sv
// Multi-slot packet generator merged with a pass-through stream at packet boundaries.
// Optional PGM_SEQ_STAMP_EN: stamp the head beat's low CNT_W bits with gen_sent.
module pgm_multi_gen
  import pgm_pkg::*;
#(
  parameter  int DATA_W     = 134,
  parameter  int SLOTS      = 4,
  parameter  int SLOT_DEPTH = 32,
  parameter  int CNT_W      = 16,
  parameter  int GAP_W      = 8,
  localparam int SW         = $clog2(SLOTS),
  localparam int AW         = $clog2(SLOT_DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_pgm_data,
  input  logic              in_pgm_data_wr,
  input  logic              in_pgm_valid,
  input  logic              in_pgm_valid_wr,
  output logic              out_pgm_alf,
  input  logic [SW-1:0]     load_slot,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_data_wr,
  output logic              load_ready,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [SW-1:0]     cfg_slot,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [GAP_W-1:0]  cfg_gap,
  output logic [DATA_W-1:0] out_pgm_data,
  output logic              out_pgm_data_wr,
  output logic              out_pgm_valid,
  output logic              out_pgm_valid_wr,
  input  logic              in_pgm_alf,
  output logic              gen_busy,
  output logic [CNT_W-1:0]  gen_sent,
  output logic              gen_err,
  output logic [CNT_W-1:0]  pt_drop_cnt
);

  gen_state_t r_state, w_next;

  logic [LW-1:0]     r_idx;
  logic [GAP_W-1:0]  r_gap_cnt, r_gap;
  logic [SW-1:0]     r_slot;
  logic [CNT_W-1:0]  r_cnt, r_sent, r_drop_cnt;
  logic              r_stop_pend, r_err, r_pt_fwd, r_pt_drop;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_wr, r_out_vld, r_out_vld_wr;

  logic [SLOTS-1:0]       w_slot_valid;
  logic [SLOTS-1:0][AW:0] w_slot_len;
  logic [DATA_W-1:0]      w_rd_data, w_gen_data;
  logic [AW-1:0]          w_rd_off;
  logic [LW-1:0]          w_len;
  logic w_ovf, w_load_en, w_start_ok, w_start_bad, w_last, w_done;
  logic w_gen_beat, w_gen_tail, w_pt_head, w_pt_tail, w_drop_head, w_drop_beat;

  assign gen_busy    = (r_state != S_IDLE);
  assign load_ready  = !gen_busy;
  assign w_load_en   = load_data_wr && load_ready;
  assign w_start_ok  = cfg_start && !gen_busy && w_slot_valid[cfg_slot];
  assign w_start_bad = cfg_start && !gen_busy && !w_slot_valid[cfg_slot];

  assign w_len      = w_slot_len[r_slot];
  // SEND holds one extra cycle (idx==len) while the tail sits in the output register
  assign w_last     = (r_state == S_SEND) && (r_idx == w_len);
  assign w_gen_beat = (r_state == S_SEND) && (r_idx < w_len);
  assign w_gen_tail = w_gen_beat && ((r_idx + LW'(1)) == w_len);
  assign w_done     = (r_cnt != '0) && ((r_sent + CNT_W'(1)) == r_cnt);

  assign w_pt_head   = in_pgm_data_wr && (in_pgm_data[HDR_HI:HDR_LO] == HDR_HEAD);
  assign w_pt_tail   = in_pgm_data_wr && (in_pgm_data[HDR_HI:HDR_LO] == HDR_TAIL);
  assign w_drop_head = w_pt_head && (r_state == S_SEND);
  assign w_drop_beat = in_pgm_data_wr && (r_pt_drop || w_drop_head);

  // Read one beat ahead: beat 0 while waiting, beat idx+1 while sending
  assign w_rd_off = (r_state == S_SEND) ? (r_idx[AW-1:0] + AW'(1)) : '0;

  pgm_tpl_ram #(
    .DATA_W     (DATA_W),
    .SLOTS      (SLOTS),
    .SLOT_DEPTH (SLOT_DEPTH)
  ) u_ram (
    .clk          (clk),
    .rst          (rst),
    .i_wr_en      (w_load_en),
    .i_wr_slot    (load_slot),
    .i_wr_data    (load_data),
    .i_rd_addr    ({r_slot, w_rd_off}),
    .o_rd_data    (w_rd_data),
    .o_slot_valid (w_slot_valid),
    .o_slot_len   (w_slot_len),
    .o_ovf        (w_ovf)
  );

  always_comb begin
    w_gen_data = w_rd_data;
`ifdef PGM_SEQ_STAMP_EN
    if (r_idx == '0) w_gen_data[CNT_W-1:0] = r_sent;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next = S_WAIT;
      S_WAIT: begin
        if (cfg_stop)                                      w_next = S_IDLE;
        else if (!r_pt_fwd && !w_pt_head && !in_pgm_alf)   w_next = S_SEND;
      end
      S_SEND: begin
        if (w_last) begin
          if (w_done || r_stop_pend || cfg_stop) w_next = S_IDLE;
          else if (r_gap == '0)                  w_next = S_WAIT;
          else                                   w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (cfg_stop)                             w_next = S_IDLE;
        else if (r_gap_cnt == r_gap - GAP_W'(1))  w_next = S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_gap_cnt   <= '0;
      r_gap       <= '0;
      r_slot      <= '0;
      r_cnt       <= '0;
      r_sent      <= '0;
      r_stop_pend <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_idx     <= (r_state == S_SEND) ? r_idx + LW'(1) : '0;
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + GAP_W'(1) : '0;
      if (w_ovf || w_start_bad) r_err <= 1'b1;
      if ((r_state == S_SEND) && cfg_stop) r_stop_pend <= 1'b1;
      if (w_last) r_sent <= r_sent + CNT_W'(1);
      if (w_start_ok) begin
        r_slot      <= cfg_slot;
        r_cnt       <= cfg_count;
        r_gap       <= cfg_gap;
        r_sent      <= '0;
        r_stop_pend <= 1'b0;
      end
    end
  end

  // Pass-through packet tracking: forwarded packets block WAIT, heads seen in SEND are dropped whole
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pt_fwd   <= 1'b0;
      r_pt_drop  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (in_pgm_data_wr) begin
      if (w_drop_head) begin
        r_pt_drop  <= 1'b1;
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end else if (r_pt_drop) begin
        if (w_pt_tail) r_pt_drop <= 1'b0;
      end else if (w_pt_head) begin
        r_pt_fwd <= 1'b1;
      end else if (w_pt_tail) begin
        r_pt_fwd <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data   <= '0;
      r_out_wr     <= 1'b0;
      r_out_vld    <= 1'b0;
      r_out_vld_wr <= 1'b0;
    end else if (w_gen_beat) begin
      r_out_data   <= w_gen_data;
      r_out_wr     <= 1'b1;
      r_out_vld    <= w_gen_tail;
      r_out_vld_wr <= w_gen_tail;
    end else begin
      r_out_data   <= in_pgm_data;
      r_out_wr     <= in_pgm_data_wr && !w_drop_beat;
      r_out_vld    <= in_pgm_valid && !w_drop_beat;
      r_out_vld_wr <= in_pgm_valid_wr && !w_drop_beat;
    end
  end

  assign out_pgm_data     = r_out_data;
  assign out_pgm_data_wr  = r_out_wr;
  assign out_pgm_valid    = r_out_vld;
  assign out_pgm_valid_wr = r_out_vld_wr;
  assign out_pgm_alf      = in_pgm_alf | (r_state == S_SEND);
  assign gen_sent         = r_sent;
  assign gen_err          = r_err;
  assign pt_drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_pgm_multi_gen.sv
// Self-checking bench for pgm_multi_gen: random templates and run parameters
// checked against a cycle-schedule model derived from the timing rules.
module tb_pgm_multi_gen;
  import pgm_pkg::*;

  localparam int DATA_W = 134, SLOTS = 4, SLOT_DEPTH = 32, CNT_W = 16, GAP_W = 8;
  localparam int SW = $clog2(SLOTS);
  typedef logic [DATA_W-1:0] w_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [DATA_W-1:0] in_pgm_data = '0, load_data = '0;
  logic in_pgm_data_wr = 0, in_pgm_valid = 0, in_pgm_valid_wr = 0, in_pgm_alf = 0;
  logic [SW-1:0] load_slot = '0, cfg_slot = '0;
  logic load_data_wr = 0, cfg_start = 0, cfg_stop = 0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic [GAP_W-1:0] cfg_gap = '0;
  logic out_pgm_alf, load_ready, out_pgm_data_wr, out_pgm_valid, out_pgm_valid_wr, gen_busy, gen_err;
  logic [DATA_W-1:0] out_pgm_data;
  logic [CNT_W-1:0] gen_sent, pt_drop_cnt;

  pgm_multi_gen dut (
    .clk(clk), .rst(rst),
    .in_pgm_data(in_pgm_data), .in_pgm_data_wr(in_pgm_data_wr),
    .in_pgm_valid(in_pgm_valid), .in_pgm_valid_wr(in_pgm_valid_wr),
    .out_pgm_alf(out_pgm_alf),
    .load_slot(load_slot), .load_data(load_data), .load_data_wr(load_data_wr), .load_ready(load_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_slot(cfg_slot), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
    .out_pgm_data(out_pgm_data), .out_pgm_data_wr(out_pgm_data_wr),
    .out_pgm_valid(out_pgm_valid), .out_pgm_valid_wr(out_pgm_valid_wr),
    .in_pgm_alf(in_pgm_alf),
    .gen_busy(gen_busy), .gen_sent(gen_sent), .gen_err(gen_err), .pt_drop_cnt(pt_drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every written beat with its cycle number
  int   q_cyc[$];
  w_t   q_dat[$];
  logic q_vw[$];
  always @(negedge clk)
    if (!rst && out_pgm_data_wr) begin
      q_cyc.push_back(cyc);
      q_dat.push_back(out_pgm_data);
      q_vw.push_back(out_pgm_valid_wr && out_pgm_valid);
    end

  w_t tpl [SLOTS][SLOT_DEPTH];
  int tlen [SLOTS];
  int n_tests = 0, n_fail = 0;

  task automatic chk(string tag, w_t obs, w_t exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_q();
    q_cyc.delete(); q_dat.delete(); q_vw.delete();
  endtask

  function automatic w_t mk_beat(int i, int n);
    w_t b;
    b[31:0]    = $urandom;
    b[63:32]   = $urandom;
    b[95:64]   = $urandom;
    b[127:96]  = $urandom;
    b[131:128] = 4'($urandom);
    b[HDR_HI:HDR_LO] = (i == 0) ? HDR_HEAD : (i == n - 1) ? HDR_TAIL : HDR_BODY;
    return b;
  endfunction

  // Expected beat i of the k-th generated packet from slot s
  function automatic w_t exp_beat(int s, int i, int k);
    w_t e;
    e = tpl[s][i];
`ifdef PGM_SEQ_STAMP_EN
    if (i == 0) e[CNT_W-1:0] = CNT_W'(k);
`endif
    if (k < 0) e = '0;
    return e;
  endfunction

  task automatic load_tpl(int s, int n);
    load_slot = SW'(s);
    for (int i = 0; i < n; i++) begin
      load_data = mk_beat(i, n);
      if (i < SLOT_DEPTH) tpl[s][i] = load_data;
      load_data_wr = 1'b1;
      tick();
    end
    load_data_wr = 1'b0;
    tlen[s] = n;
  endtask

  task automatic start_gen(int s, int c, int g, output int t);
    cfg_slot = SW'(s); cfg_count = CNT_W'(c); cfg_gap = GAP_W'(g);
    cfg_start = 1'b1;
    t = cyc;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic pt_beat(w_t d, logic last);
    in_pgm_data = d; in_pgm_data_wr = 1'b1;
    in_pgm_valid_wr = last; in_pgm_valid = last;
    tick();
    in_pgm_data_wr = 1'b0; in_pgm_valid_wr = 1'b0; in_pgm_valid = 1'b0;
  endtask

  task automatic wait_idle(string tag, int budget);
    int n = 0;
    while (gen_busy && n < budget) begin tick(); n++; end
    chk(tag, w_t'(gen_busy), w_t'(0));
  endtask

  // Schedule model: first head 3 cycles after start, packets contiguous,
  // next head gap+3 cycles after the previous tail.
  task automatic chk_run(string tag, int s, int t0, int npkt, int g);
    int h = t0 + 3;
    int idx = 0;
    int L = tlen[s];
    chk({tag, "_nbeats"}, w_t'(q_cyc.size()), w_t'(npkt * L));
    for (int k = 0; k < npkt; k++) begin
      for (int i = 0; i < L; i++) begin
        if (idx < q_cyc.size()) begin
          chk({tag, "_cyc"}, w_t'(q_cyc[idx]), w_t'(h + i));
          chk({tag, "_dat"}, q_dat[idx], exp_beat(s, i, k));
          chk({tag, "_vld"}, w_t'(q_vw[idx]), w_t'(i == L - 1));
        end
        idx++;
      end
      h = h + L - 1 + g + 3;
    end
  endtask

  initial begin
    int t, r, p0, p1;
    w_t ptd [4];

    // Reset state
    tick(3);
    chk("rst_wr", w_t'(out_pgm_data_wr), w_t'(0));
    chk("rst_data", out_pgm_data, w_t'(0));
    chk("rst_busy", w_t'(gen_busy), w_t'(0));
    chk("rst_sent", w_t'(gen_sent), w_t'(0));
    chk("rst_err", w_t'(gen_err), w_t'(0));
    chk("rst_drop", w_t'(pt_drop_cnt), w_t'(0));
    chk("rst_alf", w_t'(out_pgm_alf), w_t'(0));
    chk("rst_ldrdy", w_t'(load_ready), w_t'(1));
    rst = 1'b0;
    tick(2);

    // Counted runs: fixed 3-beat/count 4/gap 5 case, then random ones
    for (int it = 0; it < 5; it++) begin
      int s, L, c, g;
      if (it == 0) begin s = 2; L = 3; c = 4; g = 5; end
      else begin
        s = int'($urandom_range(0, SLOTS - 1)); L = int'($urandom_range(2, 8));
        c = int'($urandom_range(1, 4));         g = int'($urandom_range(0, 6));
      end
      load_tpl(s, L);
      clr_q();
      start_gen(s, c, g, t);
      chk("run_ldrdy", w_t'(load_ready), w_t'(0));
      wait_idle("run_idle", 600);
      tick(2);
      chk_run("run", s, t, c, g);
      chk("run_sent", w_t'(gen_sent), w_t'(c));
      chk("run_err", w_t'(gen_err), w_t'(0));
    end

    // Continuous run stopped in the middle of the third packet
    load_tpl(0, 4);
    clr_q();
    start_gen(0, 0, 0, t);
    tick((t + 3 + 2 * (4 + 2) + 1) - cyc);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    wait_idle("stop_idle", 100);
    tick(4);
    chk_run("stop", 0, t, 3, 0);
    chk("stop_sent", w_t'(gen_sent), w_t'(3));

    // Start while a pass-through packet is in flight
    load_tpl(3, 3);
    clr_q();
    for (int i = 0; i < 4; i++) ptd[i] = mk_beat(i, 4);
    p0 = cyc;
    pt_beat(ptd[0], 1'b0);
    cfg_slot = SW'(3); cfg_count = CNT_W'(1); cfg_gap = '0; cfg_start = 1'b1;
    pt_beat(ptd[1], 1'b0);
    cfg_start = 1'b0;
    pt_beat(ptd[2], 1'b0);
    p1 = cyc;
    pt_beat(ptd[3], 1'b1);
    wait_idle("pt_idle", 100);
    tick(2);
    chk("pt_nbeats", w_t'(q_cyc.size()), w_t'(7));
    if (q_cyc.size() == 7) begin
      for (int i = 0; i < 4; i++) begin
        chk("pt_cyc", w_t'(q_cyc[i]), w_t'(p0 + 1 + i));
        chk("pt_dat", q_dat[i], ptd[i]);
      end
      chk("pt_gen_after_tail", w_t'(q_cyc[4] > p1), w_t'(1));
      for (int i = 0; i < 3; i++) begin
        chk("pt_gen_cyc", w_t'(q_cyc[4 + i]), w_t'(q_cyc[4] + i));
        chk("pt_gen_dat", q_dat[4 + i], exp_beat(3, i, 0));
      end
    end

    // Downstream almost-full holds the generator in WAIT
    clr_q();
    in_pgm_alf = 1'b1;
    start_gen(3, 1, 0, t);
    tick(10);
    chk("alf_hold_nbeats", w_t'(q_cyc.size()), w_t'(0));
    chk("alf_hold_busy", w_t'(gen_busy), w_t'(1));
    r = cyc;
    in_pgm_alf = 1'b0;
    wait_idle("alf_idle", 100);
    tick(2);
    chk_run("alf", 3, r - 1, 1, 0);

    // Pass-through head during SEND is dropped whole
    load_tpl(2, 6);
    clr_q();
    start_gen(2, 1, 0, t);
    tick((t + 3) - cyc);
    chk("drop_alf", w_t'(out_pgm_alf), w_t'(1));
    for (int i = 0; i < 3; i++) pt_beat(mk_beat(i, 3), i == 2);
    wait_idle("drop_idle", 100);
    tick(2);
    chk_run("drop", 2, t, 1, 0);
    chk("drop_cnt", w_t'(pt_drop_cnt), w_t'(1));
    clr_q();
    p0 = cyc;
    for (int i = 0; i < 3; i++) begin ptd[i] = mk_beat(i, 3); pt_beat(ptd[i], i == 2); end
    tick(2);
    chk("fwd_nbeats", w_t'(q_cyc.size()), w_t'(3));
    if (q_cyc.size() == 3)
      for (int i = 0; i < 3; i++) begin
        chk("fwd_cyc", w_t'(q_cyc[i]), w_t'(p0 + 1 + i));
        chk("fwd_dat", q_dat[i], ptd[i]);
        chk("fwd_vld", w_t'(q_vw[i]), w_t'(i == 2));
      end

    // Overlong template: 33 beats into a 32-deep slot
    chk("ovf_err_before", w_t'(gen_err), w_t'(0));
    load_tpl(1, 33);
    tick(2);
    chk("ovf_err", w_t'(gen_err), w_t'(1));
    clr_q();
    start_gen(1, 1, 0, t);
    tick(20);
    chk("ovf_nbeats", w_t'(q_cyc.size()), w_t'(0));
    chk("ovf_busy", w_t'(gen_busy), w_t'(0));

    // Reset in the middle of a generated packet
    load_tpl(0, 5);
    clr_q();
    start_gen(0, 0, 0, t);
    tick((t + 4) - cyc);
    chk("mid_wr_before", w_t'(out_pgm_data_wr), w_t'(1));
    rst = 1'b1;
    tick();
    chk("mid_rst_wr", w_t'(out_pgm_data_wr), w_t'(0));
    chk("mid_rst_busy", w_t'(gen_busy), w_t'(0));
    chk("mid_rst_err", w_t'(gen_err), w_t'(0));
    chk("mid_rst_drop", w_t'(pt_drop_cnt), w_t'(0));
    rst = 1'b0;
    tick();
    start_gen(0, 1, 0, t);
    tick(2);
    chk("mid_slot_invalid_err", w_t'(gen_err), w_t'(1));
    chk("mid_slot_invalid_busy", w_t'(gen_busy), w_t'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
